mux_nto1_arb: RTL and testbench

MUX_NTO1_ARB -- requirements
Module: mux_nto1_arb

---
 rtl/mux_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mux_nto1_arb.sv | 84 ++++++++
 tb/tb_mux_nto1_arb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants for the N-to-1 arbitrated mux
package mux_pkg;
    localparam int   DEFAULT_WIDTH = 64;
    localparam int   DEFAULT_N     = 4;
    localparam logic MODE_FIXED    = 1'b0;
    localparam logic MODE_RR       = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] index
);
    logic [SW-1:0] r_ptr;
    logic          w_found;

    // Search starts at r_ptr and wraps, so the last winner gets lowest priority.
    always_comb begin
        int j;
        j       = 0;
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(r_ptr) + k;
            if (j >= N) j = j - N;
            if (!w_found && req[j]) begin
                w_found  = 1'b1;
                grant[j] = 1'b1;
                index    = SW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (int'(index) == N - 1) ? '0 : index + 1'b1;
        end
    end
endmodule

// File: rtl/mux_nto1_arb.sv
// rtl/mux_nto1_arb.sv - N-to-1 registered mux with fixed-select or round-robin grant
module mux_nto1_arb
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    output logic               out_valid,
    input  logic               out_ready
);
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_sel;
    logic             r_out_valid;

    logic             w_load;
    logic [N-1:0]     w_rr_req;
    logic [N-1:0]     w_rr_grant;
    logic [SW-1:0]    w_rr_index;
    logic             w_rr_advance;
    logic [N-1:0]     w_fixed_grant;
    logic [N-1:0]     w_grant;
    logic [SW-1:0]    w_grant_idx;
    logic [WIDTH-1:0] w_mux_data;

    assign w_load       = !r_out_valid || out_ready;
    assign w_rr_req     = w_load ? in_valid : '0;
    assign w_rr_advance = rst_n && (mode == MODE_RR) && (|w_rr_grant);

    rr_arbiter #(.N(N), .SW(SW)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_rr_req),
        .advance (w_rr_advance),
        .grant   (w_rr_grant),
        .index   (w_rr_index)
    );

    always_comb begin
        w_fixed_grant = '0;
        if (w_load && (int'(sel) < N) && in_valid[sel]) w_fixed_grant[sel] = 1'b1;
    end

    assign w_grant     = (mode == MODE_RR) ? w_rr_grant : w_fixed_grant;
    assign w_grant_idx = (mode == MODE_RR) ? w_rr_index : sel;
    assign in_ready    = rst_n ? w_grant : '0;

    // One-hot AND-OR select keeps the read in range even for an invalid sel.
    always_comb begin
        w_mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) w_mux_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (|w_grant) begin
                r_out_data  <= w_mux_data;
                r_out_sel   <= w_grant_idx;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_nto1_arb.sv
// tb/tb_mux_nto1_arb.sv - directed self-checking bench for mux_nto1_arb
module tb_mux_nto1_arb;
    localparam int WIDTH = 64;
    localparam int N     = 4;
    localparam int SW    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SW-1:0]      sel;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_sel;
    logic               out_valid;
    logic               out_ready;

    logic [WIDTH-1:0] ch [N];
    int checks   = 0;
    int failures = 0;

    mux_nto1_arb #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_fixed();
        rst_n = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== ch[2] || out_sel !== 2'd2) begin
            failures++;
            $display("FAIL fixed_out got v=%b d=%h s=%0d exp v=1 d=%h s=2", out_valid, out_data, out_sel, ch[2]);
        end
        checks++;
        if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_ready_next got=%b exp=0100", in_ready); end
    endtask

    task automatic test_fixed_invalid();
        sel = 2'd3; in_valid = 4'b0111;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin failures++; $display("FAIL fixed_inv_ready got=%b exp=0000", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== ch[2]) begin
            failures++;
            $display("FAIL fixed_inv_drain got v=%b d=%h exp v=0 d=%h", out_valid, out_data, ch[2]);
        end
    endtask

    task automatic test_rr_seq();
        logic [N-1:0] exp_rdy;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            checks++;
            if (in_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, in_ready, exp_rdy); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== SW'(k % 4) || out_data !== ch[k % 4]) begin
                failures++;
                $display("FAIL rr_seq[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", k, out_valid, out_sel, out_data, k % 4, ch[k % 4]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [SW-1:0] exp_sel [3];
        logic [N-1:0]  exp_rdy [3];
        exp_sel[0] = 2'd3; exp_sel[1] = 2'd0; exp_sel[2] = 2'd3;
        exp_rdy[0] = 4'b1000; exp_rdy[1] = 4'b0001; exp_rdy[2] = 4'b1000;
        in_valid = 4'b0001;
        tick();
        checks++;
        if (out_sel !== 2'd0) begin failures++; $display("FAIL wrap_setup got s=%0d exp s=0", out_sel); end
        in_valid = 4'b1001;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== exp_rdy[k]) begin failures++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", k, in_ready, exp_rdy[k]); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[k]) begin
                failures++;
                $display("FAIL wrap_sel[%0d] got v=%b s=%0d exp v=1 s=%0d", k, out_valid, out_sel, exp_sel[k]);
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 4'b1111;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=0000", k, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== ch[3]) begin
                failures++;
                $display("FAIL stall_hold[%0d] got v=%b s=%0d d=%h exp v=1 s=3 d=%h", k, out_valid, out_sel, out_data, ch[3]);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin failures++; $display("FAIL stall_release_ready got=%b exp=0001", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== ch[0]) begin
            failures++;
            $display("FAIL stall_refill got v=%b s=%0d d=%h exp v=1 s=0 d=%h", out_valid, out_sel, out_data, ch[0]);
        end
    endtask

    task automatic test_mode_switch();
        mode = 1'b0; sel = 2'd3;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin failures++; $display("FAIL mode_fixed_ready got=%b exp=1000", in_ready); end
        tick();
        checks++;
        if (out_sel !== 2'd3) begin failures++; $display("FAIL mode_fixed_sel got=%0d exp=3", out_sel); end
        mode = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin failures++; $display("FAIL mode_rr_ready got=%b exp=0010", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== ch[1]) begin
            failures++;
            $display("FAIL mode_rr_sel got v=%b s=%0d d=%h exp v=1 s=1 d=%h", out_valid, out_sel, out_data, ch[1]);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin failures++; $display("FAIL rmid_ready got=%b exp=0000", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0) begin
            failures++;
            $display("FAIL rmid_state got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_sel);
        end
        rst_n = 1'b1; out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin failures++; $display("FAIL rmid_first_ready got=%b exp=0001", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== ch[0]) begin
            failures++;
            $display("FAIL rmid_first got v=%b s=%0d d=%h exp v=1 s=0 d=%h", out_valid, out_sel, out_data, ch[0]);
        end
    endtask

    initial begin
        ch[0] = 64'h0123_4567_89AB_CDEF;
        ch[1] = 64'h5A5A_0000_FFFF_0001;
        ch[2] = 64'hC000_0000_0000_0000;
        ch[3] = 64'hDEAD_BEEF_0000_0003;
        in_data = {ch[3], ch[2], ch[1], ch[0]};
        test_reset();
        test_fixed();
        test_fixed_invalid();
        test_rr_seq();
        test_wrap();
        test_stall();
        test_mode_switch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
